// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : RV32I memory-access stage. Issues one data-memory transaction
//               (req/gnt, then rvalid) per load/store, aligns and extends load
//               data, replicates store data into byte lanes, passes non-memory
//               results through, and flags misaligned and bus-timeout errors.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    // Execute side
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic            ex_mem_en,
    input  logic            ex_store,
    input  logic            ex_unsigned,
    input  logic [1:0]      ex_size,
    input  logic [XLEN-1:0] ex_addr,
    input  logic [XLEN-1:0] ex_wdata,
    input  logic [4:0]      ex_rd,
    // Data-memory side
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    // Writeback side
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [4:0]      wb_rd,
    output logic            wb_we,
    output logic [XLEN-1:0] wb_data,
    output logic            exc_misalign,
    output logic            exc_bus_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    // Last counter value of a phase; the phase times out on the edge ending it.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            store_q, store_d;
    logic            unsigned_q, unsigned_d;
    logic [1:0]      size_q, size_d;
    logic [1:0]      lane_q, lane_d;
    logic [3:0]      be_q, be_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic            wb_we_q, wb_we_d;
    logic            exc_misalign_q, exc_misalign_d;
    logic            exc_bus_err_q, exc_bus_err_d;

    logic            misalign;
    logic [3:0]      new_be;
    logic [XLEN-1:0] new_wdata;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_data;

    // Decode alignment, byte enables and lane-replicated store data of the incoming op
    always_comb begin
        misalign  = 1'b0;
        new_be    = 4'b1111;
        new_wdata = ex_wdata;
        case (ex_size)
            2'b00: begin
                new_be    = 4'b0001 << ex_addr[1:0];
                new_wdata = {4{ex_wdata[7:0]}};
            end
            2'b01: begin
                misalign  = ex_addr[0];
                new_be    = ex_addr[1] ? 4'b1100 : 4'b0011;
                new_wdata = {2{ex_wdata[15:0]}};
            end
            2'b10: begin
                misalign  = |ex_addr[1:0];
            end
            default: begin
                misalign  = 1'b1;
            end
        endcase
    end

    // Select the addressed lane of the read word and sign/zero-extend it
    always_comb begin
        ld_byte = dmem_rdata[{lane_q, 3'b000} +: 8];
        ld_half = dmem_rdata[{lane_q[1], 4'b0000} +: 16];
        case (size_q)
            2'b00:   ld_data = {{(XLEN-8){ld_byte[7] & ~unsigned_q}}, ld_byte};
            2'b01:   ld_data = {{(XLEN-16){ld_half[15] & ~unsigned_q}}, ld_half};
            default: ld_data = dmem_rdata;
        endcase
    end

    // Next-state and datapath update for the transaction sequencer
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        store_d        = store_q;
        unsigned_d     = unsigned_q;
        size_d         = size_q;
        lane_d         = lane_q;
        be_d           = be_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        rd_d           = rd_q;
        wb_data_d      = wb_data_q;
        wb_we_d        = wb_we_q;
        exc_misalign_d = exc_misalign_q;
        exc_bus_err_d  = exc_bus_err_q;

        case (state_q)
            S_IDLE: begin
                if (ex_valid) begin
                    rd_d           = ex_rd;
                    cnt_d          = 8'd0;
                    exc_misalign_d = 1'b0;
                    exc_bus_err_d  = 1'b0;
                    if (!ex_mem_en) begin
                        state_d   = S_RESP;
                        wb_data_d = ex_addr;
                        wb_we_d   = (ex_rd != 5'd0);
                    end else if (misalign) begin
                        // Faulting address is reported as the result
                        state_d        = S_RESP;
                        wb_data_d      = ex_addr;
                        wb_we_d        = 1'b0;
                        exc_misalign_d = 1'b1;
                    end else begin
                        state_d    = S_REQ;
                        store_d    = ex_store;
                        unsigned_d = ex_unsigned;
                        size_d     = ex_size;
                        lane_d     = ex_addr[1:0];
                        be_d       = new_be;
                        addr_d     = {ex_addr[XLEN-1:2], 2'b00};
                        wdata_d    = new_wdata;
                        wb_data_d  = '0;
                        wb_we_d    = 1'b0;
                    end
                end
            end
            S_REQ: begin
                if (dmem_gnt) begin
                    state_d = S_WAIT;
                    cnt_d   = 8'd0;
                end else if (cnt_q == WAIT_LAST) begin
                    state_d       = S_RESP;
                    exc_bus_err_d = 1'b1;
                    wb_we_d       = 1'b0;
                    wb_data_d     = addr_q;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WAIT: begin
                if (dmem_rvalid) begin
                    state_d = S_RESP;
                    if (!store_q) begin
                        wb_data_d = ld_data;
                        wb_we_d   = (rd_q != 5'd0);
                    end
                end else if (cnt_q == WAIT_LAST) begin
                    state_d       = S_RESP;
                    exc_bus_err_d = 1'b1;
                    wb_we_d       = 1'b0;
                    wb_data_d     = addr_q;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                if (wb_ready) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // State and datapath registers; reset abandons any transaction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= 8'd0;
            store_q        <= 1'b0;
            unsigned_q     <= 1'b0;
            size_q         <= 2'b00;
            lane_q         <= 2'b00;
            be_q           <= 4'b0000;
            addr_q         <= '0;
            wdata_q        <= '0;
            rd_q           <= 5'd0;
            wb_data_q      <= '0;
            wb_we_q        <= 1'b0;
            exc_misalign_q <= 1'b0;
            exc_bus_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            store_q        <= store_d;
            unsigned_q     <= unsigned_d;
            size_q         <= size_d;
            lane_q         <= lane_d;
            be_q           <= be_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            rd_q           <= rd_d;
            wb_data_q      <= wb_data_d;
            wb_we_q        <= wb_we_d;
            exc_misalign_q <= exc_misalign_d;
            exc_bus_err_q  <= exc_bus_err_d;
        end
    end

    // Output mapping: handshake strobes follow the state, payloads come from registers
    always_comb begin
        ex_ready     = (state_q == S_IDLE);
        dmem_req     = (state_q == S_REQ);
        dmem_we      = (state_q == S_REQ) && store_q;
        dmem_be      = be_q;
        dmem_addr    = addr_q;
        dmem_wdata   = wdata_q;
        wb_valid     = (state_q == S_RESP);
        wb_rd        = rd_q;
        wb_we        = wb_we_q;
        wb_data      = wb_data_q;
        exc_misalign = exc_misalign_q;
        exc_bus_err  = exc_bus_err_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Directed self-checking bench for load_store_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_ready, ex_mem_en, ex_store, ex_unsigned;
    logic [1:0]  ex_size;
    logic [31:0] ex_addr, ex_wdata;
    logic [4:0]  ex_rd;
    logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        wb_valid, wb_ready, wb_we, exc_misalign, exc_bus_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    load_store_unit #(.XLEN(32), .MAX_WAIT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_mem_en(ex_mem_en),
        .ex_store(ex_store), .ex_unsigned(ex_unsigned), .ex_size(ex_size),
        .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_we(wb_we),
        .wb_data(wb_data), .exc_misalign(exc_misalign), .exc_bus_err(exc_bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_op(input logic mem_en, input logic st, input logic uns,
                            input logic [1:0] sz, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [4:0] rd);
        ex_valid    = 1'b1;
        ex_mem_en   = mem_en;
        ex_store    = st;
        ex_unsigned = uns;
        ex_size     = sz;
        ex_addr     = addr;
        ex_wdata    = wd;
        ex_rd       = rd;
    endtask

    // One load/store with gnt and rvalid each in their first cycle
    task automatic mem_op(input string tag, input logic st, input logic uns,
                          input logic [1:0] sz, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [4:0] rd,
                          input logic [31:0] rdata, input logic [3:0] e_be,
                          input logic [31:0] e_wdata, input logic [31:0] e_data,
                          input logic e_we);
        @(negedge clk);
        chk({tag, "_ready"}, 32'(ex_ready), 32'd1);
        drive_op(1'b1, st, uns, sz, addr, wd, rd);
        @(negedge clk);
        ex_valid = 1'b0;
        chk({tag, "_req"},  32'(dmem_req), 32'd1);
        chk({tag, "_we"},   32'(dmem_we), 32'(st));
        chk({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
        chk({tag, "_be"},   32'(dmem_be), 32'(e_be));
        if (st) chk({tag, "_wdata"}, dmem_wdata, e_wdata);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        chk({tag, "_reqdrop"}, 32'(dmem_req), 32'd0);
        chk({tag, "_nowb"},    32'(wb_valid), 32'd0);
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        chk({tag, "_wbv"},   32'(wb_valid), 32'd1);
        chk({tag, "_wbwe"},  32'(wb_we), 32'(e_we));
        chk({tag, "_wbrd"},  32'(wb_rd), 32'(rd));
        if (!st) chk({tag, "_data"}, wb_data, e_data);
        @(negedge clk);
        chk({tag, "_done"},  32'(wb_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        ex_valid    = 1'b0;
        ex_mem_en   = 1'b0;
        ex_store    = 1'b0;
        ex_unsigned = 1'b0;
        ex_size     = 2'b00;
        ex_addr     = '0;
        ex_wdata    = '0;
        ex_rd       = '0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = '0;
        wb_ready    = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req",   32'(dmem_req), 32'd0);
        chk("rst_we",    32'(dmem_we), 32'd0);
        chk("rst_be",    32'(dmem_be), 32'd0);
        chk("rst_addr",  dmem_addr, 32'd0);
        chk("rst_wbv",   32'(wb_valid), 32'd0);
        chk("rst_wbwe",  32'(wb_we), 32'd0);
        chk("rst_wbd",   wb_data, 32'd0);
        chk("rst_exc",   32'({exc_misalign, exc_bus_err}), 32'd0);
        chk("rst_ready", 32'(ex_ready), 32'd1);
        rst_n = 1'b1;

        // Loads: lane selection and extension
        mem_op("lw",   1'b0, 1'b0, 2'b10, 32'h100, 32'h0, 5'd3, 32'hDEADBEEF, 4'b1111, 32'h0, 32'hDEADBEEF, 1'b1);
        mem_op("lb",   1'b0, 1'b0, 2'b00, 32'h103, 32'h0, 5'd4, 32'h80112233, 4'b1000, 32'h0, 32'hFFFFFF80, 1'b1);
        mem_op("lbu",  1'b0, 1'b1, 2'b00, 32'h103, 32'h0, 5'd4, 32'h80112233, 4'b1000, 32'h0, 32'h00000080, 1'b1);
        mem_op("lh",   1'b0, 1'b0, 2'b01, 32'h102, 32'h0, 5'd6, 32'h80112233, 4'b1100, 32'h0, 32'hFFFF8011, 1'b1);
        mem_op("lhu",  1'b0, 1'b1, 2'b01, 32'h100, 32'h0, 5'd7, 32'h80119233, 4'b0011, 32'h0, 32'h00009233, 1'b1);
        mem_op("lb1",  1'b0, 1'b0, 2'b00, 32'h101, 32'h0, 5'd8, 32'h80112233, 4'b0010, 32'h0, 32'h00000022, 1'b1);
        mem_op("lwr0", 1'b0, 1'b0, 2'b10, 32'h104, 32'h0, 5'd0, 32'h12345678, 4'b1111, 32'h0, 32'h12345678, 1'b0);

        // Stores: byte enables and lane replication
        mem_op("sh",   1'b1, 1'b0, 2'b01, 32'h206, 32'h0000ABCD, 5'd9, 32'h0, 4'b1100, 32'hABCDABCD, 32'h0, 1'b0);
        mem_op("sb",   1'b1, 1'b0, 2'b00, 32'h205, 32'hFFFFFF5A, 5'd9, 32'h0, 4'b0010, 32'h5A5A5A5A, 32'h0, 1'b0);
        mem_op("sw",   1'b1, 1'b0, 2'b10, 32'h300, 32'h12345678, 5'd9, 32'h0, 4'b1111, 32'h12345678, 32'h0, 1'b0);

        // Misaligned word: exception next cycle, no bus request
        @(negedge clk);
        drive_op(1'b1, 1'b0, 1'b0, 2'b10, 32'h101, 32'h0, 5'd10);
        @(negedge clk);
        ex_valid = 1'b0;
        chk("mis_wbv", 32'(wb_valid), 32'd1);
        chk("mis_exc", 32'(exc_misalign), 32'd1);
        chk("mis_we",  32'(wb_we), 32'd0);
        chk("mis_req", 32'(dmem_req), 32'd0);
        @(negedge clk);
        chk("mis_req2", 32'(dmem_req), 32'd0);
        chk("mis_done", 32'(wb_valid), 32'd0);

        // Illegal size 11 is treated as misaligned
        drive_op(1'b1, 1'b0, 1'b0, 2'b11, 32'h100, 32'h0, 5'd10);
        @(negedge clk);
        ex_valid = 1'b0;
        chk("sz3_exc", 32'(exc_misalign), 32'd1);
        chk("sz3_req", 32'(dmem_req), 32'd0);
        @(negedge clk);

        // Grant withheld: bus error after 15 request cycles, then Writeback stall
        wb_ready = 1'b0;
        drive_op(1'b1, 1'b0, 1'b0, 2'b10, 32'h400, 32'h0, 5'd11);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            ex_valid = 1'b0;
            chk("to_req",  32'(dmem_req), 32'd1);
            chk("to_nowb", 32'(wb_valid), 32'd0);
        end
        @(negedge clk);
        chk("to_req0", 32'(dmem_req), 32'd0);
        drive_op(1'b0, 1'b0, 1'b0, 2'b00, 32'h77, 32'h0, 5'd12);
        for (int i = 0; i < 4; i++) begin
            chk("stall_wbv",   32'(wb_valid), 32'd1);
            chk("stall_buserr", 32'(exc_bus_err), 32'd1);
            chk("stall_we",    32'(wb_we), 32'd0);
            chk("stall_rd",    32'(wb_rd), 32'd11);
            chk("stall_ready", 32'(ex_ready), 32'd0);
            if (i == 3) wb_ready = 1'b1;
            @(negedge clk);
        end
        ex_valid = 1'b0;
        chk("stall_rel_wbv",   32'(wb_valid), 32'd0);
        chk("stall_rel_ready", 32'(ex_ready), 32'd1);

        // rvalid withheld: bus error in the response phase
        @(negedge clk);
        drive_op(1'b1, 1'b0, 1'b0, 2'b10, 32'h500, 32'h0, 5'd13);
        @(negedge clk);
        ex_valid = 1'b0;
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            chk("rto_nowb", 32'(wb_valid), 32'd0);
        end
        @(negedge clk);
        chk("rto_wbv", 32'(wb_valid), 32'd1);
        chk("rto_err", 32'(exc_bus_err), 32'd1);
        chk("rto_we",  32'(wb_we), 32'd0);
        @(negedge clk);

        // Non-memory ADD back-to-back: one result every two cycles
        drive_op(1'b0, 1'b0, 1'b0, 2'b00, 32'h42, 32'h0, 5'd5);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("alu_wbv",  32'(wb_valid), 32'd1);
            chk("alu_data", wb_data, 32'h42);
            chk("alu_we",   32'(wb_we), 32'd1);
            chk("alu_rd",   32'(wb_rd), 32'd5);
            chk("alu_exc",  32'({exc_misalign, exc_bus_err}), 32'd0);
            @(negedge clk);
            chk("alu_gap",  32'(wb_valid), 32'd0);
            chk("alu_rdy",  32'(ex_ready), 32'd1);
        end
        drive_op(1'b0, 1'b0, 1'b0, 2'b00, 32'h99, 32'h0, 5'd0);
        @(negedge clk);
        ex_valid = 1'b0;
        chk("alu_r0_data", wb_data, 32'h99);
        chk("alu_r0_we",   32'(wb_we), 32'd0);
        @(negedge clk);

        // Asynchronous reset during WAIT abandons the load
        drive_op(1'b1, 1'b0, 1'b0, 2'b10, 32'h600, 32'h0, 5'd14);
        @(negedge clk);
        ex_valid = 1'b0;
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_req",  32'(dmem_req), 32'd0);
        chk("arst_addr", dmem_addr, 32'd0);
        chk("arst_wbv",  32'(wb_valid), 32'd0);
        chk("arst_wbd",  wb_data, 32'd0);
        chk("arst_rd",   32'(wb_rd), 32'd0);
        chk("arst_rdy",  32'(ex_ready), 32'd1);
        #1;
        rst_n = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hCAFEF00D;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        chk("arst_lost", 32'(wb_valid), 32'd0);
        @(negedge clk);
        chk("arst_lost2", 32'(wb_valid), 32'd0);
        chk("arst_idle",  32'(ex_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
